// File: rtl/gol_pkg.sv
// Shared types, Life rule constants and helpers for the Game of Life engine.
// Define GOL_TORUS_EN to make the grid toroidal. Otherwise cells outside the grid count as dead.
package gol_pkg;

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    localparam int BIRTH      = 3;
    localparam int SURVIVE_LO = 2;
    localparam int SURVIVE_HI = 3;

`ifdef GOL_TORUS_EN
    localparam bit TORUS = 1'b1;
`else
    localparam bit TORUS = 1'b0;
`endif

    function automatic int cell_index(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

    function automatic logic next_cell(input logic alive, input logic [3:0] cnt);
        if (alive)
            return (cnt >= 4'(SURVIVE_LO)) && (cnt <= 4'(SURVIVE_HI));
        return cnt == 4'(BIRTH);
    endfunction

endpackage

// File: rtl/gol_if.sv
// Control/status bundle of the Life engine. The host is the master and the engine is the slave.
interface gol_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
);
    logic                 load;
    logic [ROWS*COLS-1:0] seed;
    logic                 start;
    logic                 step;
    logic                 stop;
    logic [GEN_W-1:0]     max_gen;
    logic [ROWS*COLS-1:0] grid;
    logic [GEN_W-1:0]     gen_count;
    logic                 busy;
    logic                 gen_done;
    logic                 stable;
    logic                 extinct;

    modport master (
        output load, seed, start, step, stop, max_gen,
        input  grid, gen_count, busy, gen_done, stable, extinct
    );

    modport slave (
        input  load, seed, start, step, stop, max_gen,
        output grid, gen_count, busy, gen_done, stable, extinct
    );
endinterface

// File: rtl/gol_row_eval.sv
// Combinational next-state of one grid row from its two neighbouring rows.
// The column edges wrap when the package's TORUS flag is set. Otherwise they count as dead.
module gol_row_eval
    import gol_pkg::*;
#(
    parameter int COLS = 8
) (
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] cur,
    input  logic [COLS-1:0] below,
    input  logic            above_vld,
    input  logic            below_vld,
    output logic [COLS-1:0] nxt
);
    logic [COLS-1:0] a_m, b_m;
    logic [COLS+1:0] a_x, c_x, b_x;
    logic [3:0]      cnt;

    assign a_m = above_vld ? above : '0;
    assign b_m = below_vld ? below : '0;

    // Bit 0 of each padded row is the left neighbour of column 0. Bit COLS+1 is the right neighbour of the last column.
    assign a_x = {TORUS ? a_m[0] : 1'b0, a_m, TORUS ? a_m[COLS-1] : 1'b0};
    assign c_x = {TORUS ? cur[0] : 1'b0, cur, TORUS ? cur[COLS-1] : 1'b0};
    assign b_x = {TORUS ? b_m[0] : 1'b0, b_m, TORUS ? b_m[COLS-1] : 1'b0};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nxt = '0;
        cnt = '0;
        for (int c = 0; c < COLS; c++) begin
            cnt = 4'(a_x[c]) + 4'(a_x[c+1]) + 4'(a_x[c+2])
                + 4'(c_x[c])                + 4'(c_x[c+2])
                + 4'(b_x[c]) + 4'(b_x[c+1]) + 4'(b_x[c+2]);
            nxt[c] = next_cell(cur[c], cnt);
        end
    end
endmodule

// File: rtl/gol_life_engine.sv
// Sequential Game of Life engine. It evaluates one row per clock into a shadow buffer and then commits the whole generation.
// Toroidal edges are enabled by defining GOL_TORUS_EN. The timing is identical in both builds.
module gol_life_engine
    import gol_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input logic  clk,
    input logic  reset,
    gol_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int N  = ROWS * COLS;
    typedef logic [RW-1:0] row_t;

    state_t          state, state_nxt;
    row_t            row, up_row, dn_row;
    logic            last_row, above_vld, below_vld;
    logic [COLS-1:0] above, cur, below, nxt_row;
    logic [N-1:0]    grid_q, shadow;
    logic [GEN_W-1:0] gen_q;
    logic            gen_done_q, stable_q, extinct_q;
    logic            run_mode, stop_lat, accept, finish;

    assign last_row  = (row == row_t'(ROWS - 1));
    assign up_row    = (row == '0) ? row_t'(ROWS - 1) : row - row_t'(1);
    assign dn_row    = last_row ? '0 : row + row_t'(1);
    assign above_vld = TORUS || (row != '0);
    assign below_vld = TORUS || !last_row;
    assign above     = grid_q[cell_index(int'(up_row), 0, COLS) +: COLS];
    assign cur       = grid_q[cell_index(int'(row), 0, COLS) +: COLS];
    assign below     = grid_q[cell_index(int'(dn_row), 0, COLS) +: COLS];

    gol_row_eval #(.COLS(COLS)) u_row_eval (
        .above     (above),
        .cur       (cur),
        .below     (below),
        .above_vld (above_vld),
        .below_vld (below_vld),
        .nxt       (nxt_row)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start || bus.step) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_row) state_nxt = COMMIT;
            end
            COMMIT: begin
                finish = !run_mode || stop_lat || (shadow == grid_q) || (shadow == '0)
                      || ((bus.max_gen != '0)
                          && (({1'b0, gen_q} + (GEN_W+1)'(1)) >= {1'b0, bus.max_gen}));
                state_nxt = finish ? IDLE : CALC;
            end
            default: state_nxt = IDLE;
        endcase
        // A load wins over everything and also aborts any generation in flight.
        if (bus.load) begin
            state_nxt = IDLE;
            accept    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            row        <= '0;
            grid_q     <= '0;
            gen_q      <= '0;
            gen_done_q <= 1'b0;
            stable_q   <= 1'b0;
            extinct_q  <= 1'b0;
            run_mode   <= 1'b0;
            stop_lat   <= 1'b0;
        end else begin
            state      <= state_nxt;
            gen_done_q <= 1'b0;
            if (bus.load) begin
                grid_q    <= bus.seed;
                gen_q     <= '0;
                stable_q  <= 1'b0;
                extinct_q <= 1'b0;
                run_mode  <= 1'b0;
                stop_lat  <= 1'b0;
                row       <= '0;
            end else begin
                if (accept) begin
                    run_mode <= bus.start;
                    stop_lat <= 1'b0;
                    row      <= '0;
                end
                if (state == CALC) row <= last_row ? '0 : row + row_t'(1);
                if (state != IDLE && bus.stop) stop_lat <= 1'b1;
                if (state == COMMIT) begin
                    grid_q     <= shadow;
                    gen_done_q <= 1'b1;
                    stable_q   <= (shadow == grid_q);
                    extinct_q  <= (shadow == '0);
                    if (gen_q != '1) gen_q <= gen_q + GEN_W'(1);
                    if (finish) stop_lat <= 1'b0;
                end
            end
        end
    end

    // NOTE: the shadow buffer is storage that is fully rewritten before each commit, so it has no reset.
    always_ff @(posedge clk) begin
        if (state == CALC)
            shadow[cell_index(int'(row), 0, COLS) +: COLS] <= nxt_row;
    end

    assign bus.grid      = grid_q;
    assign bus.gen_count = gen_q;
    assign bus.busy      = (state != IDLE);
    assign bus.gen_done  = gen_done_q;
    assign bus.stable    = stable_q;
    assign bus.extinct   = extinct_q;
endmodule

// File: doc/gol_life_engine.md
Name: gol_life_engine

Overview:
Parametrised, sequential Conway's Game of Life engine for a ROWS x COLS grid. It evaluates one row per clock into a shadow buffer, then commits the whole generation at once. It supports single-step, free-run, bounded-run and stop control, and it flags stable and extinct grids. It replaces the fixed 8x8 combinational evolve datapath plus its separate FSM with one self-contained block.

Parameters:
ROWS, 8, grid height; must be >= 3
COLS, 8, grid width; must be >= 3
GEN_W, 16, width of generation counter and max_gen

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load  in  1  pulse; copy seed into grid
seed  in  ROWS*COLS  initial grid; cell (r,c) at bit r*COLS+c
start  in  1  pulse; begin free-run
step  in  1  pulse; compute exactly one generation
stop  in  1  pulse; halt after current generation completes
max_gen  in  GEN_W  free-run generation limit; 0 = unlimited
grid  out  ROWS*COLS  current committed generation
gen_count  out  GEN_W  generations committed since last load
busy  out  1  high in CALC/COMMIT
gen_done  out  1  one-cycle pulse on each commit
stable  out  1  last commit produced grid identical to previous
extinct  out  1  last commit produced all-zero grid

Behaviour:
- Reset (reset=0, async): grid=0, gen_count=0, busy=0, gen_done=0, stable=0, extinct=0, state=IDLE, row pointer=0, run/stop latches cleared. The shadow buffer is don't-care.
- Rule: neighbour count 0..8 (4-bit). A live cell survives on 2 or 3. A dead cell is born on 3. All other cells are dead.
- Edges (default): cells outside the grid count as dead.
- IDLE:
  - load has priority: grid<=seed; gen_count<=0; stable<=0; extinct<=0.
  - Else start: set run mode, go to CALC with row=0.
  - Else step: set single mode, go to CALC with row=0.
  - If start and step are asserted together, start wins.
- CALC: each cycle, next_row[row] is computed from committed rows row-1, row, row+1 and row increments. After row ROWS-1, go to COMMIT. This takes ROWS cycles.
- COMMIT (1 cycle):
  - grid<=shadow; gen_count++ (saturates at all-ones); gen_done=1.
  - stable<=(shadow==grid); extinct<=(shadow==0).
  - Return to IDLE if any of: single mode, stop latched, shadow==grid, shadow==0, or (max_gen!=0 and gen_count+1>=max_gen). Otherwise go to CALC with row=0.
- Latency: step accepted at edge N -> gen_done high and grid updated in cycle N+ROWS+1.
- stop during CALC/COMMIT is latched and takes effect at the next COMMIT. stop in IDLE is ignored.
- load during CALC/COMMIT aborts the generation: shadow is discarded, grid<=seed, counters and flags are cleared, state goes to IDLE, and no gen_done is issued.
- start/step while busy are ignored.
- Free-run from an all-zero grid: one generation is computed, extinct=1, gen_count=1, then IDLE.

Optional Feature:
GOL_TORUS_EN defined: toroidal edges. Row indices wrap modulo ROWS and column indices wrap modulo COLS. Undefined: out-of-grid neighbours are dead. Timing and the control FSM are identical in both builds.

Decomposition:
- gol_pkg: state enum (IDLE, CALC, COMMIT); rule constants BIRTH=3, SURVIVE_LO=2, SURVIVE_HI=3; cell-index function.
- Sub-module gol_row_eval (combinational): inputs are the above, current and below rows plus edge-valid flags; output is the next row of COLS bits. The engine instantiates it once and reuses it every CALC cycle.

Test Plan:
- Blinker step: load 64'h0000_0000_1C00_0000, step -> after 9 cycles gen_done=1, grid=64'h0000_0008_0808_0000, gen_count=1, stable=0.
- Still life: load 64'h0000_0000_0000_0303, start -> after one generation grid unchanged, stable=1, busy=0, gen_count=1.
- Extinction: load 64'h0000_0000_0000_0001, step -> grid=0, extinct=1.
- Bounded run: blinker seed, max_gen=5, start -> exactly 5 gen_done pulses, gen_count=5, grid=64'h0000_0008_0808_0000. A second run with stop pulsed during generation 2 must end with gen_count=2.
- Edge mode: load 64'h8100_0000_0000_0081, step -> with GOL_TORUS_EN, grid unchanged and stable=1; without it, grid=0 and extinct=1.
- Abort/reset: during CALC, (a) pulse load -> grid=seed, no gen_done, state IDLE; (b) drive reset low mid-CALC -> all outputs 0 immediately, without waiting for a clock edge.
